output_mem_reader: RTL and testbench

Readout engine for the 64×32 result memory. On a start pulse it reads a contiguous range of words through the memory's synchronous read port and streams them out on a valid/ready interface, with `out_last` on the final word. It sits between the result memory and the host/testbench dump path. It is the read-side counterpart of the processor's write port into that memory.

---
 rtl/output_mem_reader_pkg.sv | 21 ++
 rtl/output_mem_reader_fifo.sv | 60 ++++++
 rtl/output_mem_reader.sv | 148 ++++++++++++++
 tb/tb_output_mem_reader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/output_mem_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : output_mem_reader_pkg
// Brief   : Shared result-memory geometry and readout FSM state encoding.
// Revision: 1.0
// ============================================================================
package output_mem_reader_pkg;

    localparam int c_data_w = 32;
    localparam int c_addr_w = 6;
    localparam int c_depth  = 1 << c_addr_w;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/output_mem_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo2
// Brief   : Two-entry synchronous FIFO; push and pop together when full is legal.
// Revision: 1.0
// ============================================================================
module sync_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = pop && (r_count != 2'd0);
    assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/output_mem_reader.sv
`default_nettype none
// ============================================================================
// Module  : output_mem_reader
// Brief   : Streams a contiguous, wrapping range of the result memory out on a
//           valid/ready port with a last-word flag.
// Revision: 1.0
// ============================================================================
module output_mem_reader
    import output_mem_reader_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int ADDR_W = c_addr_w,
    parameter int DEPTH  = c_depth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [ADDR_W:0] c_depth_len = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one       = (ADDR_W+1)'(1);

    state_t            r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_issued;
    logic [ADDR_W:0]   r_accepted;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pending;
    logic              r_pending_last;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W:0]   w_len_clamped;
    logic              w_pop;
    logic              w_credit;
    logic              w_issue_last;
    logic [2:0]        w_occupancy;
    logic [DATA_W:0]   w_fifo_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [1:0]        w_fifo_count;

    assign w_len_clamped = (length > c_depth_len) ? c_depth_len : length;
    assign w_pop         = out_valid && out_ready;
    assign w_issue_last  = ((r_issued + c_one) == r_len);

    // Words held or owed to the FIFO once this cycle's pop retires; a new read
    // is only allowed when its data is guaranteed a free slot.
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_pending} - {2'b00, w_pop};
    assign w_credit    = w_fifo_full ? (w_pop && !r_pending) : (w_occupancy < 3'd2);
    assign mem_re      = (r_state == S_RUN) && w_credit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_len          <= '0;
            r_issued       <= '0;
            r_accepted     <= '0;
            r_addr         <= '0;
            r_pending      <= 1'b0;
            r_pending_last <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_pending      <= mem_re;
            r_pending_last <= mem_re && w_issue_last;
            r_done         <= 1'b0;
            if (mem_re) begin
                r_addr   <= r_addr + 1'b1;
                r_issued <= r_issued + c_one;
            end
            if (w_pop) begin
                r_accepted <= r_accepted + c_one;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_clamped == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_RUN;
                            r_busy     <= 1'b1;
                            r_addr     <= start_addr;
                            r_len      <= w_len_clamped;
                            r_issued   <= '0;
                            r_accepted <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (mem_re && w_issue_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Finish on the handshake of the final word so done follows it directly.
                    if (w_pop && out_last && !r_pending && (w_fifo_count == 2'd1)
                        && ((r_accepted + c_one) == r_len)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    sync_fifo2 #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_pending),
        .pop   (w_pop),
        .din   ({r_pending_last, mem_rdata}),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_addr  = r_addr;
    assign out_valid = !w_fifo_empty;
    assign out_data  = w_fifo_head[DATA_W-1:0];
    assign out_last  = w_fifo_head[DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_output_mem_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_output_mem_reader
// Brief   : Self-checking bench for output_mem_reader with a queue-based model.
// Revision: 1.0
// ============================================================================
module tb_output_mem_reader;

    localparam int DW  = 32;
    localparam int AW  = 6;
    localparam int DEP = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    logic [DW-1:0] mem_arr [DEP];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    output_mem_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    // Synchronous-read result memory
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_arr[mem_addr];
    end

    int            cyc       = 0;
    int            issued    = 0;
    int            hs        = 0;
    int            stab_err  = 0;
    int            outs_err  = 0;
    int            valid_cyc = 0;
    int            busy_cyc  = 0;
    int            hs_edges[$];
    int            done_edges[$];
    logic [DW:0]   got[$];
    logic          p_valid = 1'b0;
    logic          p_ready = 1'b0;
    logic          p_last  = 1'b0;
    logic [DW-1:0] p_data  = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            p_valid <= 1'b0;
            issued  <= hs;
        end else begin
            if (issued - hs > 2) outs_err <= outs_err + 1;
            if (p_valid && !p_ready &&
                (!out_valid || out_data !== p_data || out_last !== p_last))
                stab_err <= stab_err + 1;
            if (mem_re)    issued    <= issued + 1;
            if (out_valid) valid_cyc <= valid_cyc + 1;
            if (busy)      busy_cyc  <= busy_cyc + 1;
            if (done)      done_edges.push_back(cyc);
            if (out_valid && out_ready) begin
                got.push_back({out_last, out_data});
                hs_edges.push_back(cyc);
                hs <= hs + 1;
            end
            p_valid <= out_valid;
            p_ready <= out_ready;
            p_data  <= out_data;
            p_last  <= out_last;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic run_xfer(input int sa, input int len, input int mode,
                            input int restart_at, input string nm);
        int          hs0   = got.size();
        int          he0   = hs_edges.size();
        int          de0   = done_edges.size();
        int          iss0  = issued;
        int          vc0   = valid_cyc;
        int          bc0   = busy_cyc;
        int          n     = (len > DEP) ? DEP : len;
        int          s_edge;
        int          errs  = 0;
        int          k     = 0;
        logic [DW:0] exp_q[$];

        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1), mem_arr[(sa + i) % DEP]});

        @(negedge clk);
        start      = 1'b1;
        start_addr = AW'(sa);
        length     = (AW+1)'(len);
        out_ready  = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        s_edge     = cyc - 1;
        start      = 1'b0;
        start_addr = AW'($urandom);
        length     = (AW+1)'($urandom);
        while (done_edges.size() == de0 && k < 600) begin
            k++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            start = (k == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, " completion"}, 64'(done_edges.size() > de0), 64'd1);
        repeat (3) @(negedge clk);

        chk({nm, " word count"}, 64'(got.size() - hs0), 64'(n));
        for (int i = 0; i < n && hs0 + i < got.size(); i++)
            if (got[hs0 + i] !== exp_q[i]) errs++;
        chk({nm, " data/last errors"}, 64'(errs), 64'd0);
        chk({nm, " done pulses"}, 64'(done_edges.size() - de0), 64'd1);
        chk({nm, " reads issued"}, 64'(issued - iss0), 64'(n));
        chk({nm, " stall stability errors"}, 64'(stab_err), 64'd0);
        chk({nm, " outstanding overflow"}, 64'(outs_err), 64'd0);
        if (n == 0) begin
            chk({nm, " done latency"}, 64'(done_edges[de0] - s_edge), 64'd1);
            chk({nm, " valid cycles"}, 64'(valid_cyc - vc0), 64'd0);
            chk({nm, " busy cycles"}, 64'(busy_cyc - bc0), 64'd0);
        end else if (mode == 0 && hs_edges.size() - he0 == n) begin
            chk({nm, " first word latency"}, 64'(hs_edges[he0] - s_edge), 64'd3);
            chk({nm, " gapless stream"}, 64'(hs_edges[he0 + n - 1] - hs_edges[he0]), 64'(n - 1));
            chk({nm, " done latency"}, 64'(done_edges[de0] - s_edge), 64'(n + 3));
        end
    endtask

    initial begin
        int de_r;
        for (int i = 0; i < DEP; i++) mem_arr[i] = DW'(i + 'h100);
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        out_ready  = 1'b0;
        #1;
        chk("reset outputs",
            64'({busy, done, mem_re, mem_addr, out_valid, out_data, out_last}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_xfer(0, 64, 0, -1, "full sweep");
        run_xfer(62, 4, 0, -1, "wrap");
        run_xfer(20, 5, 1, -1, "stall toggle");
        run_xfer(7, 0, 0, -1, "zero length");
        run_xfer(3, 100, 0, -1, "clamped length");
        run_xfer(5, 10, 0, 3, "restart ignored");

        // abort mid-transfer with reset
        de_r = done_edges.size();
        @(negedge clk);
        start      = 1'b1;
        start_addr = 6'd0;
        length     = 7'd40;
        out_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort outputs",
            64'({busy, done, mem_re, mem_addr, out_valid, out_data, out_last}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort no done", 64'(done_edges.size() - de_r), 64'd0);
        chk("abort idle busy", 64'(busy), 64'd0);

        run_xfer(10, 2, 0, -1, "post reset");

        for (int i = 0; i < DEP; i++) mem_arr[i] = $urandom;
        for (int t = 0; t < 6; t++)
            run_xfer($urandom_range(0, DEP - 1), $urandom_range(0, 90), 2,
                     ($urandom_range(0, 1) != 0) ? $urandom_range(1, 8) : -1,
                     $sformatf("random %0d", t));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
